// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master (CS active-low, sclk idle low, MSB first) with MISO capture.
module spi_master #(
    parameter int DATA_W  = 4,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              CS,
    output logic              MOSI,
    input  logic              MISO
);
    localparam int DVW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW  = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t            state;
    logic [DVW-1:0]    div;
    logic [BW-1:0]     bits;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_next;
    logic              div_end;

    assign div_end = div == DVW'(CLK_DIV - 1);
    assign tx_next = tx_sh << 1;
    // MISO is sampled on the edge that raises sclk, i.e. the slave's pre-edge bit
    assign rx_next = (rx_sh << 1) | DATA_W'(MISO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            bits    <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            CS      <= 1'b1;
            MOSI    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    tx_sh <= tx_data;
                    MOSI  <= tx_data[DATA_W-1];
                    CS    <= 1'b0;
                    busy  <= 1'b1;
                    div   <= '0;
                    bits  <= '0;
                    state <= SETUP;
                end
                SETUP: if (div_end) begin
                    div   <= '0;
                    sclk  <= 1'b1;
                    rx_sh <= rx_next;
                    state <= HIGH;
                end else div <= div + 1'b1;
                HIGH: if (div_end) begin
                    div   <= '0;
                    sclk  <= 1'b0;
                    bits  <= bits + 1'b1;
                    if (bits != BW'(DATA_W - 1)) begin
                        tx_sh <= tx_next;
                        MOSI  <= tx_next[DATA_W-1];
                    end
                    state <= LOW;
                end else div <= div + 1'b1;
                LOW: if (div_end) begin
                    div <= '0;
                    if (bits == BW'(DATA_W)) begin
                        CS      <= 1'b1;
                        MOSI    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sh;
                        state   <= IDLE;
                    end else begin
                        sclk  <= 1'b1;
                        rx_sh <= rx_next;
                        state <= HIGH;
                    end
                end else div <= div + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: two masters (CLK_DIV=2 and CLK_DIV=1), each driving a behavioural 4-bit LED shift slave.
module tb_spi_master;
    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic [3:0] tx    [2];
    logic       busy  [2];
    logic       done  [2];
    logic [3:0] rx    [2];
    logic       sclk  [2];
    logic       cs    [2];
    logic       mosi  [2];
    logic       miso  [2];
    logic [3:0] leds  [2];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(4), .CLK_DIV(2)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .tx_data(tx[0]), .busy(busy[0]), .done(done[0]),
        .rx_data(rx[0]), .sclk(sclk[0]), .CS(cs[0]), .MOSI(mosi[0]), .MISO(miso[0]));
    spi_master #(.DATA_W(4), .CLK_DIV(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .tx_data(tx[1]), .busy(busy[1]), .done(done[1]),
        .rx_data(rx[1]), .sclk(sclk[1]), .CS(cs[1]), .MOSI(mosi[1]), .MISO(miso[1]));

    // Slave: shifts MOSI in on rising sclk while selected, shifts its MSB out on MISO; never reset
    initial begin
        leds[0] = 4'h0;
        leds[1] = 4'h0;
    end
    always @(posedge sclk[0]) if (!cs[0]) leds[0] <= {leds[0][2:0], mosi[0]};
    always @(posedge sclk[1]) if (!cs[1]) leds[1] <= {leds[1][2:0], mosi[1]};
    assign miso[0] = leds[0][3];
    assign miso[1] = leds[1][3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int d, input logic [3:0] w);
        start[d] = 1'b1;
        tx[d] = w;
        @(posedge clk); #1;
        start[d] = 1'b0;
        chk("accept_busy", 32'(busy[d]), 1);
        chk("accept_cs", 32'(cs[d]), 0);
        chk("accept_mosi", 32'(mosi[d]), 32'(w[3]));
    endtask

    // Follows one frame to its done edge: length, sclk edges, MOSI bits at each rise, CS, rx, slave leds
    task automatic track(input int d, input logic [3:0] w, input logic [3:0] exp_rx, input bit hammer);
        int cyc = 0;
        int rises = 0;
        logic [3:0] got = 4'h0;
        logic ps = sclk[d];
        bit cs_ok = 1'b1;
        while (!done[d] && cyc < 200) begin
            if (hammer) begin
                start[d] = 1'b1;
                tx[d] = 4'($urandom_range(15));
            end
            @(posedge clk); #1;
            cyc++;
            if (sclk[d] && !ps) begin
                rises++;
                got = {got[2:0], mosi[d]};
            end
            ps = sclk[d];
            if (!done[d] && cs[d]) cs_ok = 1'b0;
        end
        start[d] = 1'b0;
        chk("frame_len", 32'(cyc), 32'((d == 1 ? 1 : 2) * 9));
        chk("sclk_rises", 32'(rises), 4);
        chk("mosi_bits", 32'(got), 32'(w));
        chk("cs_low_whole_frame", 32'(cs_ok), 1);
        chk("done_pulse", 32'(done[d]), 1);
        chk("done_busy", 32'(busy[d]), 0);
        chk("done_cs", 32'(cs[d]), 1);
        chk("done_sclk", 32'(sclk[d]), 0);
        chk("done_mosi", 32'(mosi[d]), 0);
        chk("rx_data", 32'(rx[d]), 32'(exp_rx));
        chk("slave_leds", 32'(leds[d]), 32'(w));
    endtask

    task automatic idle_after(input int d, input logic [3:0] exp_rx);
        @(posedge clk); #1;
        chk("done_width", 32'(done[d]), 0);
        chk("idle_cs", 32'(cs[d]), 1);
        chk("idle_busy", 32'(busy[d]), 0);
        chk("rx_hold", 32'(rx[d]), 32'(exp_rx));
    endtask

    initial begin
        logic [3:0] e;
        logic [3:0] w;
        int rises;
        int cyc;
        int d;
        logic ps;
        rst = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        tx[0] = 4'h0; tx[1] = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs", 32'(cs[i]), 1);
            chk("rst_sclk", 32'(sclk[i]), 0);
            chk("rst_mosi", 32'(mosi[i]), 0);
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_done", 32'(done[i]), 0);
            chk("rst_rx", 32'(rx[i]), 0);
        end
        // first frame, then a second one returning the first word via MISO
        e = leds[0];
        launch(0, 4'b1011);
        track(0, 4'b1011, e, 1'b0);
        idle_after(0, e);
        e = leds[0];
        launch(0, 4'b0110);
        track(0, 4'b0110, e, 1'b0);
        chk("second_rx_is_first_word", 32'(rx[0]), 32'(4'b1011));
        idle_after(0, e);
        // start hammered with changing tx_data for a whole frame
        e = leds[0];
        launch(0, 4'b1100);
        track(0, 4'b1100, e, 1'b1);
        idle_after(0, e);
        // start in the done cycle: CS high for exactly one cycle
        e = leds[0];
        launch(0, 4'b0101);
        track(0, 4'b0101, e, 1'b0);
        chk("b2b_cs_high", 32'(cs[0]), 1);
        e = leds[0];
        launch(0, 4'b1010);
        track(0, 4'b1010, e, 1'b0);
        idle_after(0, e);
        // reset after the second rising sclk
        launch(0, 4'b1001);
        rises = 0;
        cyc = 0;
        ps = sclk[0];
        while (rises < 2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (sclk[0] && !ps) rises++;
            ps = sclk[0];
        end
        chk("rst_wait_rises", 32'(rises), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_cs", 32'(cs[0]), 1);
        chk("midrst_sclk", 32'(sclk[0]), 0);
        chk("midrst_mosi", 32'(mosi[0]), 0);
        chk("midrst_busy", 32'(busy[0]), 0);
        chk("midrst_done", 32'(done[0]), 0);
        chk("midrst_rx", 32'(rx[0]), 0);
        cyc = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done[0] || !cs[0]) cyc++;
        end
        chk("midrst_quiet", 32'(cyc), 0);
        e = leds[0];
        launch(0, 4'b0011);
        track(0, 4'b0011, e, 1'b0);
        idle_after(0, e);
        // CLK_DIV=1 instance
        e = leds[1];
        launch(1, 4'b1111);
        track(1, 4'b1111, e, 1'b0);
        idle_after(1, e);
        // random words on both instances
        for (int i = 0; i < 8; i++) begin
            d = i % 2;
            w = 4'($urandom_range(15));
            e = leds[d];
            launch(d, w);
            track(d, w, e, 1'b0);
            idle_after(d, e);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
